sram_2d_sync_ctrl: RTL

//  Synchronous, parametrised row/column-addressed SRAM with a valid/ready request port.
//  Per-byte write enables and a configurable read latency (1 or 2).

---
 rtl/sram_2d_sync_ctrl_pkg.sv | 30 +++
 rtl/sram_2d_sync_ctrl_if.sv | 38 +++
 rtl/sram_2d_sync_ctrl_array.sv | 50 +++++
 rtl/sram_2d_sync_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/sram_2d_sync_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_2d_pkg
// Description : Shared types and helpers for the row/column addressed SRAM
//               controller: FSM state encoding, linear address helper and
//               byte-lane count for the default word width.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_2d_pkg;

  // Default word width and the byte-lane count that goes with it.
  localparam int DATA_W_DEF = 16;
  localparam int NBYTES     = DATA_W_DEF / 8;

  // Controller states: zero-init sweep, then normal service.
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Linear word index {row,col}; the caller narrows the result to its
  // address width.
  function automatic logic [31:0] lin_addr(input logic [31:0] row,
                                           input logic [31:0] col,
                                           input int          col_w);
    return (row << col_w) | col;
  endfunction

endpackage : sram_2d_pkg
`default_nettype wire

// File: rtl/sram_2d_sync_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_2d_sync_ctrl_if
// Description : Request/response bundle of the SRAM controller. The master
//               issues valid/ready requests, the slave (controller) returns
//               read data and status.
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_2d_sync_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ROW_W  = 6,
  parameter int COL_W  = 6
);

  logic                  cs_n;
  logic                  req_valid;
  logic                  req_ready;
  logic                  rw;
  logic [ROW_W-1:0]      row;
  logic [COL_W-1:0]      col;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wbe;
  logic [DATA_W-1:0]     rdata;
  logic                  rdata_vld;
  logic                  init_done;

  modport master (
    output cs_n, req_valid, rw, row, col, wdata, wbe,
    input  req_ready, rdata, rdata_vld, init_done
  );

  modport slave (
    input  cs_n, req_valid, rw, row, col, wdata, wbe,
    output req_ready, rdata, rdata_vld, init_done
  );

endinterface : sram_2d_sync_ctrl_if
`default_nettype wire

// File: rtl/sram_2d_sync_ctrl_array.sv
`default_nettype none
// ============================================================================
// Module      : sram_2d_array
// Description : Single shared-port synchronous word array with per-byte write
//               enables and a registered read output. No control logic; the
//               caller never reads and writes in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_2d_array #(
  parameter int DATA_W = 16,
  parameter int AW     = 12
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic [AW-1:0]         addr_i,
  input  wire logic                  we_i,
  input  wire logic [DATA_W/8-1:0]   be_i,
  input  wire logic [DATA_W-1:0]     wdata_i,
  input  wire logic                  re_i,
  output logic      [DATA_W-1:0]     rdata_o
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** AW;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Byte-lane write: only enabled lanes of the addressed word change.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (we_i && be_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  // Registered read; holds the last word read until the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : sram_2d_array
`default_nettype wire

// File: rtl/sram_2d_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_2d_sync_ctrl
// Description : Row/column addressed synchronous SRAM with valid/ready request
//               port, byte write enables, read latency 1 or 2 and a hardware
//               zero-init sweep after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_2d_sync_ctrl
  import sram_2d_pkg::*;
#(
  parameter int              DATA_W   = 16,
  parameter int              ROW_W    = 6,
  parameter int              COL_W    = 6,
  parameter int              RD_LAT   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  wire logic          clk,
  input  wire logic          rst,
  sram_2d_sync_ctrl_if.slave bus
);

  localparam int AW = ROW_W + COL_W;
  localparam int NB = DATA_W / 8;

  // Sweep counter carries one extra bit; its MSB flags sweep completion so
  // the counter parks instead of wrapping.
  state_e          state_q, state_d;
  logic [AW:0]     cnt_q, cnt_d;

  logic            w_run;
  logic            w_accept;
  logic            w_wr;
  logic            w_rd;
  logic [AW-1:0]   w_user_addr;
  logic [AW-1:0]   w_arr_addr;
  logic            w_arr_we;
  logic [NB-1:0]   w_arr_be;
  logic [DATA_W-1:0] w_arr_wdata;
  logic [DATA_W-1:0] w_arr_rdata;
  logic            vld1_q;
  logic            w_vld_out;
  logic [DATA_W-1:0] w_rdata_out;

  // State and sweep counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: INIT walks every address once, then RUN forever.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_d[AW]) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  assign w_run         = (state_q == ST_RUN);
  assign bus.req_ready = w_run;
  assign bus.init_done = w_run;

  // A request in the reset cycle is dropped so a same-cycle write cannot land.
  assign w_accept    = bus.req_valid & w_run & ~bus.cs_n & ~rst;
  assign w_wr        = w_accept & ~bus.rw;
  assign w_rd        = w_accept &  bus.rw;
  assign w_user_addr = AW'(lin_addr(32'(bus.row), 32'(bus.col), COL_W));

  // Array port mux: the sweep owns the port in INIT, the user in RUN.
  always_comb begin
    w_arr_addr  = w_user_addr;
    w_arr_we    = w_wr;
    w_arr_be    = bus.wbe;
    w_arr_wdata = bus.wdata;
    if (!w_run) begin
      w_arr_addr  = cnt_q[AW-1:0];
      w_arr_we    = ~rst;
      w_arr_be    = '1;
      w_arr_wdata = INIT_VAL;
    end
  end

  sram_2d_array #(
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .addr_i  (w_arr_addr),
    .we_i    (w_arr_we),
    .be_i    (w_arr_be),
    .wdata_i (w_arr_wdata),
    .re_i    (w_rd),
    .rdata_o (w_arr_rdata)
  );

  // First read-pipeline valid, aligned with the array's registered read.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld1_q <= 1'b0;
    end else begin
      vld1_q <= w_rd;
    end
  end

  if (DATA_W % 8 != 0) begin : g_bad_width
    $error("sram_2d_sync_ctrl: DATA_W must be a multiple of 8");
  end

  if (RD_LAT == 1) begin : g_lat1
    assign w_vld_out   = vld1_q;
    assign w_rdata_out = w_arr_rdata;
  end else if (RD_LAT == 2) begin : g_lat2
    logic              vld2_q;
    logic [DATA_W-1:0] rdata2_q;

    // Extra output stage; captures only real read results so rdata holds.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld2_q   <= 1'b0;
        rdata2_q <= '0;
      end else begin
        vld2_q <= vld1_q;
        if (vld1_q) begin
          rdata2_q <= w_arr_rdata;
        end
      end
    end

    assign w_vld_out   = vld2_q;
    assign w_rdata_out = rdata2_q;
  end else begin : g_bad_lat
    $error("sram_2d_sync_ctrl: RD_LAT must be 1 or 2");
    assign w_vld_out   = 1'b0;
    assign w_rdata_out = '0;
  end

  // A result emerging in a reset cycle belongs to a dropped read.
  assign bus.rdata_vld = w_vld_out & ~rst;
  assign bus.rdata     = w_rdata_out;

endmodule : sram_2d_sync_ctrl
`default_nettype wire
